// File: rtl/lsu_pkg.sv
// lsu_pkg: shared op encodings, FSM state type and width defaults for the load/store unit.
package lsu_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_SW  = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_SB  = 3'd4;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RESP
    } state_e;
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: little-endian byte extraction/extension for loads and byte merge for SB.
module lsu_byte_lane import lsu_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        op_i,
    input  logic              sel_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic [7:0]        sbyte_i,
    output logic [DATA_W-1:0] load_o,
    output logic [DATA_W-1:0] merged_o
);
    logic [7:0] lane;
    assign lane   = sel_i ? word_i[15:8] : word_i[7:0];
    assign load_o = op_i == OP_LB  ? {{(DATA_W-8){lane[7]}}, lane} :
                    op_i == OP_LBU ? {{(DATA_W-8){1'b0}}, lane} : word_i;
    always_comb begin
        merged_o = word_i;
        merged_o[{sel_i, 3'b000} +: 8] = sbyte_i;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding LSU sequencing word/byte loads and stores to a one-cycle-latency memory.
module load_store_unit import lsu_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [2:0]        req_rd_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic [2:0]        resp_rd_o,
    output logic              resp_err_o,
    output logic              mem_write_en_o,
    output logic              mem_read_en_o,
    output logic [ADDR_W-1:0] mem_access_addr_o,
    output logic [DATA_W-1:0] mem_write_data_o,
    input  logic [DATA_W-1:0] mem_read_data_i
);
    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d, rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              err_q, err_d, req_err;
    logic [DATA_W-1:0] load_data, merged;
    lsu_byte_lane #(.DATA_W(DATA_W)) u_lane (
        .op_i     (op_q),
        .sel_i    (addr_q[0]),
        .word_i   (mem_read_data_i),
        .sbyte_i  (wdata_q[7:0]),
        .load_o   (load_data),
        .merged_o (merged)
    );
    assign req_err = (req_op_i > OP_SB) || ((req_op_i == OP_LW || req_op_i == OP_SW) && req_addr_i[0]);
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: if (req_valid_i) begin
                op_d    = req_op_i;
                addr_d  = req_addr_i;
                wdata_d = req_wdata_i;
                rd_d    = req_rd_i;
                err_d   = req_err;
                rdata_d = '0;
                state_d = req_err ? ST_RESP : (req_op_i == OP_SW ? ST_WR : ST_RD);
            end
            ST_RD:   state_d = ST_CAP;
            // SB is a read-modify-write: the merged word replaces the store data
            ST_CAP: if (op_q == OP_SB) begin
                wdata_d = merged;
                state_d = ST_WR;
            end else begin
                rdata_d = load_data;
                state_d = ST_RESP;
            end
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = resp_ready_i ? ST_IDLE : ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end
    assign req_ready_o       = state_q == ST_IDLE;
    assign mem_read_en_o     = state_q == ST_RD;
    assign mem_write_en_o    = state_q == ST_WR;
    assign mem_access_addr_o = (mem_read_en_o || mem_write_en_o) ? {1'b0, addr_q[ADDR_W-1:1]} : '0;
    assign mem_write_data_o  = mem_write_en_o ? wdata_q : '0;
    assign resp_valid_o      = state_q == ST_RESP;
    assign resp_rdata_o      = resp_valid_o ? rdata_q : '0;
    assign resp_rd_o         = resp_valid_o ? rd_q : '0;
    assign resp_err_o        = resp_valid_o && err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven checks of the LSU against a behavioural one-cycle-latency memory.
module tb_load_store_unit;
    import lsu_pkg::*;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic        mem_write_en, mem_read_en;
    logic [2:0]  req_op, req_rd, resp_rd;
    logic [15:0] req_addr, req_wdata, resp_rdata, mem_access_addr, mem_write_data, mem_read_data;
    logic [15:0] mem [0:65535];
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    load_store_unit #(.DATA_W(16), .ADDR_W(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_op_i          (req_op),
        .req_addr_i        (req_addr),
        .req_wdata_i       (req_wdata),
        .req_rd_i          (req_rd),
        .resp_valid_o      (resp_valid),
        .resp_ready_i      (resp_ready),
        .resp_rdata_o      (resp_rdata),
        .resp_rd_o         (resp_rd),
        .resp_err_o        (resp_err),
        .mem_write_en_o    (mem_write_en),
        .mem_read_en_o     (mem_read_en),
        .mem_access_addr_o (mem_access_addr),
        .mem_write_data_o  (mem_write_data),
        .mem_read_data_i   (mem_read_data)
    );
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_access_addr] <= mem_write_data;
        if (mem_read_en) mem_read_data <= mem[mem_access_addr];
    end
    assert property (@(posedge clk) !(mem_read_en && mem_write_en));
    always @(negedge clk)
        if (mem_read_en && mem_write_en) begin
            errors++;
            $display("FAIL both_enables: read_en=1 write_en=1 required never both");
        end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic zero_chk(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_rdata"}, resp_rdata, 0);
        chk({tag, "_resp_rd"}, resp_rd, 0);
        chk({tag, "_resp_err"}, resp_err, 0);
        chk({tag, "_mem_en"}, {mem_read_en, mem_write_en}, 0);
        chk({tag, "_mem_addr"}, mem_access_addr, 0);
        chk({tag, "_mem_wdata"}, mem_write_data, 0);
    endtask
    task automatic issue(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wd, input logic [2:0] rd);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_rd    = rd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask
    task automatic run(output int lat, output int nrd, output int nwr,
                       output logic [15:0] maddr, output logic [15:0] wdat, output bit bad);
        lat = 1; nrd = 0; nwr = 0; maddr = 0; wdat = 0; bad = 0;
        while (lat <= 20) begin
            @(negedge clk);
            if (req_ready) bad = 1;
            if (resp_valid) break;
            if (mem_read_en) begin nrd++; maddr = mem_access_addr; end
            if (mem_write_en) begin nwr++; maddr = mem_access_addr; wdat = mem_write_data; end
            if (!mem_read_en && !mem_write_en && (mem_access_addr != 0 || mem_write_data != 0)) bad = 1;
            lat++;
        end
    endtask
    task automatic ack();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask
    task automatic abort_sb(input int d);
        int nw;
        issue(OP_SB, 16'h000A, 16'h0055, 3'd6);
        repeat (d) @(posedge clk);
        @(negedge clk);
        chk($sformatf("abort%0d_pre_rd_en", d), mem_read_en, d == 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        zero_chk($sformatf("abort%0d", d));
        rst = 1'b0;
        nw = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_write_en) nw++;
        end
        chk($sformatf("abort%0d_no_write", d), nw, 0);
    endtask
    typedef struct {
        logic [2:0]  op;
        logic [15:0] addr, wd;
        logic [2:0]  rd;
        logic [15:0] rdata;
        logic        err;
        int          lat, nrd, nwr;
        logic [15:0] maddr, wdat;
    } vec_t;
    vec_t vt[18];
    initial begin
        int lat, nrd, nwr;
        logic [15:0] maddr, wdat, h_rdata;
        logic [2:0] h_rd;
        bit bad;
        vt[0]  = '{OP_SW,  16'h0002, 16'h7F22, 3'd1, 16'h0000, 1'b0, 2, 0, 1, 16'h0001, 16'h7F22};
        vt[1]  = '{OP_SW,  16'h000A, 16'd50,   3'd2, 16'h0000, 1'b0, 2, 0, 1, 16'h0005, 16'd50};
        vt[2]  = '{OP_LW,  16'h000A, 16'h0000, 3'd3, 16'd50,   1'b0, 3, 1, 0, 16'h0005, 16'h0000};
        vt[3]  = '{OP_SW,  16'h000A, 16'h1234, 3'd4, 16'h0000, 1'b0, 2, 0, 1, 16'h0005, 16'h1234};
        vt[4]  = '{OP_SB,  16'h000B, 16'h00AB, 3'd5, 16'h0000, 1'b0, 4, 1, 1, 16'h0005, 16'hAB34};
        vt[5]  = '{OP_LB,  16'h000B, 16'h0000, 3'd6, 16'hFFAB, 1'b0, 3, 1, 0, 16'h0005, 16'h0000};
        vt[6]  = '{OP_LBU, 16'h000B, 16'h0000, 3'd7, 16'h00AB, 1'b0, 3, 1, 0, 16'h0005, 16'h0000};
        vt[7]  = '{OP_LW,  16'h000A, 16'h0000, 3'd0, 16'hAB34, 1'b0, 3, 1, 0, 16'h0005, 16'h0000};
        vt[8]  = '{OP_SB,  16'h000A, 16'h3C80, 3'd1, 16'h0000, 1'b0, 4, 1, 1, 16'h0005, 16'hAB80};
        vt[9]  = '{OP_LB,  16'h000A, 16'h0000, 3'd2, 16'hFF80, 1'b0, 3, 1, 0, 16'h0005, 16'h0000};
        vt[10] = '{OP_LBU, 16'h000A, 16'h0000, 3'd3, 16'h0080, 1'b0, 3, 1, 0, 16'h0005, 16'h0000};
        vt[11] = '{OP_LB,  16'h0003, 16'h0000, 3'd4, 16'h007F, 1'b0, 3, 1, 0, 16'h0001, 16'h0000};
        vt[12] = '{OP_LB,  16'h0002, 16'h0000, 3'd5, 16'h0022, 1'b0, 3, 1, 0, 16'h0001, 16'h0000};
        vt[13] = '{OP_LW,  16'h0003, 16'h0000, 3'd6, 16'h0000, 1'b1, 1, 0, 0, 16'h0000, 16'h0000};
        vt[14] = '{3'd6,   16'h0004, 16'h1111, 3'd7, 16'h0000, 1'b1, 1, 0, 0, 16'h0000, 16'h0000};
        vt[15] = '{3'd5,   16'h0004, 16'h2222, 3'd1, 16'h0000, 1'b1, 1, 0, 0, 16'h0000, 16'h0000};
        vt[16] = '{3'd7,   16'h0006, 16'h3333, 3'd2, 16'h0000, 1'b1, 1, 0, 0, 16'h0000, 16'h0000};
        vt[17] = '{OP_SW,  16'h0001, 16'hFFFF, 3'd3, 16'h0000, 1'b1, 1, 0, 0, 16'h0000, 16'h0000};
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_rd = '0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        zero_chk("reset");
        rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            issue(vt[i].op, vt[i].addr, vt[i].wd, vt[i].rd);
            run(lat, nrd, nwr, maddr, wdat, bad);
            chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("v%0d_rdata", i), resp_rdata, vt[i].rdata);
            chk($sformatf("v%0d_err", i), resp_err, vt[i].err);
            chk($sformatf("v%0d_rd", i), resp_rd, vt[i].rd);
            chk($sformatf("v%0d_reads", i), nrd, vt[i].nrd);
            chk($sformatf("v%0d_writes", i), nwr, vt[i].nwr);
            chk($sformatf("v%0d_mem_addr", i), maddr, vt[i].maddr);
            chk($sformatf("v%0d_mem_wdata", i), wdat, vt[i].wdat);
            chk($sformatf("v%0d_idle_outputs", i), bad, 0);
            ack();
        end
        issue(OP_LW, 16'h000A, 16'h0000, 3'd5);
        run(lat, nrd, nwr, maddr, wdat, bad);
        chk("hold_latency", lat, 3);
        h_rdata = resp_rdata;
        h_rd = resp_rd;
        chk("hold_rdata", h_rdata, 16'hAB80);
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata_stable", resp_rdata, h_rdata);
            chk("hold_rd_stable", resp_rd, h_rd);
            chk("hold_err_stable", resp_err, 0);
            chk("hold_req_ready", req_ready, 0);
        end
        ack();
        @(negedge clk);
        chk("hold_release_ready", req_ready, 1);
        chk("hold_release_valid", resp_valid, 0);
        abort_sb(0);
        abort_sb(1);
        issue(OP_LW, 16'h000A, 16'h0000, 3'd1);
        run(lat, nrd, nwr, maddr, wdat, bad);
        chk("after_abort_word", resp_rdata, 16'hAB80);
        ack();
        issue(OP_SW, 16'h0004, 16'h5A5A, 3'd2);
        @(negedge clk);
        chk("rst_in_wr_en", mem_write_en, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        zero_chk("rst_wr");
        rst = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
